// File: rtl/boot_sequencer.sv
// Power-on loader: copies the EEPROM boot image into microcode, MLU slice and
// MLU lookahead SRAMs, then releases the core by pulling N_BOOTED low.
module boot_sequencer #(
    parameter int UCODE_AW = 12,
    parameter int SLICE_AW = 12,
    parameter int LOOK_AW  = 17,
    parameter int ROM_AW   = 18,
    parameter int ROM_LAT  = 2
) (
    input  logic               CLK,
    input  logic               N_RST,
    output logic [ROM_AW-1:0]  ROM_ADDR,
    output logic               ROM_N_OE,
    input  logic [7:0]         ROM_DATA,
    output logic [LOOK_AW-1:0] ADDR,
    output logic [31:0]        DATA,
    output logic               CONTROL_N_WE,
    output logic               MLU_SLICE_N_WE,
    output logic               MLU_LOOKAHEAD_N_WE,
    output logic               N_BOOTED
);

    localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [LAT_W-1:0]   LAT_MAX   = LAT_W'(ROM_LAT - 1);
    localparam logic [LOOK_AW-1:0] UCODE_MAX = LOOK_AW'((1 << UCODE_AW) - 1);
    localparam logic [LOOK_AW-1:0] SLICE_MAX = LOOK_AW'((1 << SLICE_AW) - 1);
    localparam logic [LOOK_AW-1:0] LOOK_MAX  = LOOK_AW'((1 << LOOK_AW) - 1);

    typedef enum logic [2:0] {ST_FETCH, ST_SETUP, ST_WRITE, ST_HOLD, ST_DONE} state_t;
    typedef enum logic [1:0] {PH_UCODE, PH_SLICE, PH_LOOK} phase_t;

    state_t             r_state, w_state_nxt;
    phase_t             r_phase, w_phase_nxt;
    logic [LAT_W-1:0]   r_lat;
    logic [1:0]         r_byte;
    logic [ROM_AW-1:0]  r_rom_addr;
    logic [31:0]        r_word;
    logic [LOOK_AW-1:0] r_addr;
    logic [31:0]        r_data;

    logic               w_fetch_done;
    logic               w_last_byte;
    logic               w_last_addr;
    logic [LOOK_AW-1:0] w_addr_max;
    logic [31:0]        w_word_nxt;

    assign w_fetch_done = (r_lat == LAT_MAX);
    assign w_last_byte  = (r_phase != PH_UCODE) || (r_byte == 2'd3);
    assign w_last_addr  = (r_addr == w_addr_max);

    always_comb begin
        unique case (r_phase)
            PH_UCODE: w_addr_max = UCODE_MAX;
            PH_SLICE: w_addr_max = SLICE_MAX;
            default:  w_addr_max = LOOK_MAX;
        endcase
    end

    // Byte phases always present the byte on lane 0 with the upper lanes zero.
    always_comb begin
        w_word_nxt = r_word;
        if (r_phase != PH_UCODE) begin
            w_word_nxt = {24'd0, ROM_DATA};
        end else begin
            unique case (r_byte)
                2'd0:    w_word_nxt[7:0]   = ROM_DATA;
                2'd1:    w_word_nxt[15:8]  = ROM_DATA;
                2'd2:    w_word_nxt[23:16] = ROM_DATA;
                default: w_word_nxt[31:24] = ROM_DATA;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            r_state <= ST_FETCH;
            r_phase <= PH_UCODE;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_phase_nxt        = r_phase;
        CONTROL_N_WE       = 1'b1;
        MLU_SLICE_N_WE     = 1'b1;
        MLU_LOOKAHEAD_N_WE = 1'b1;
        ROM_N_OE           = 1'b0;
        N_BOOTED           = 1'b1;
        unique case (r_state)
            ST_FETCH: begin
                if (w_fetch_done && w_last_byte) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                w_state_nxt = ST_HOLD;
                unique case (r_phase)
                    PH_UCODE: CONTROL_N_WE       = 1'b0;
                    PH_SLICE: MLU_SLICE_N_WE     = 1'b0;
                    default:  MLU_LOOKAHEAD_N_WE = 1'b0;
                endcase
            end
            ST_HOLD: begin
                w_state_nxt = ST_FETCH;
                if (w_last_addr) begin
                    unique case (r_phase)
                        PH_UCODE: w_phase_nxt = PH_SLICE;
                        PH_SLICE: w_phase_nxt = PH_LOOK;
                        default:  w_state_nxt = ST_DONE;
                    endcase
                end
            end
            default: begin
                ROM_N_OE = 1'b1;
                N_BOOTED = 1'b0;
            end
        endcase
    end

    // The EEPROM image is contiguous, so ROM_ADDR simply counts up across phases.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            r_lat      <= '0;
            r_byte     <= '0;
            r_rom_addr <= '0;
            r_word     <= '0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            if (r_state == ST_FETCH) begin
                if (w_fetch_done) begin
                    r_lat      <= '0;
                    r_rom_addr <= r_rom_addr + ROM_AW'(1);
                    r_word     <= w_word_nxt;
                    r_byte     <= w_last_byte ? 2'd0 : r_byte + 2'd1;
                    if (w_last_byte) r_data <= w_word_nxt;
                end else begin
                    r_lat <= r_lat + LAT_W'(1);
                end
            end
            if (r_state == ST_HOLD) begin
                if (!w_last_addr) begin
                    r_addr <= r_addr + LOOK_AW'(1);
                end else if (r_phase != PH_LOOK) begin
                    r_addr <= '0;
                end
            end
        end
    end

    assign ROM_ADDR = r_rom_addr;
    assign ADDR     = r_addr;
    assign DATA     = r_data;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: small-image instance (ROM_LAT=1) for write
// sequence, strobe rules, DONE and mid-boot reset; ROM_LAT=3 instance for timing.
module tb_boot_sequencer;

    localparam int T_A = ((4*1+3) << 2) + (1+3) * ((1 << 2) + (1 << 2));
    localparam int T_B = ((4*3+3) << 1) + (3+3) * ((1 << 1) + (1 << 1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- instance A ----------------
    logic       rst_a = 1'b0;
    logic [7:0] rom_addr_a;
    logic       rom_n_oe_a;
    logic [7:0] rom_data_a;
    logic [1:0] addr_a;
    logic [31:0] data_a;
    logic       cwe_a, swe_a, lwe_a, nb_a;
    logic       rom_rand = 1'b0;
    logic [7:0] rnd = 8'd0;

    assign rom_data_a = rom_rand ? rnd : rom_addr_a;

    boot_sequencer #(.UCODE_AW(2), .SLICE_AW(2), .LOOK_AW(2), .ROM_AW(8), .ROM_LAT(1)) u_a (
        .CLK(clk), .N_RST(rst_a), .ROM_ADDR(rom_addr_a), .ROM_N_OE(rom_n_oe_a),
        .ROM_DATA(rom_data_a), .ADDR(addr_a), .DATA(data_a), .CONTROL_N_WE(cwe_a),
        .MLU_SLICE_N_WE(swe_a), .MLU_LOOKAHEAD_N_WE(lwe_a), .N_BOOTED(nb_a));

    int edges_a;
    always @(posedge clk or negedge rst_a)
        if (!rst_a) edges_a <= 0;
        else        edges_a <= edges_a + 1;

    logic [63:0] wlog_a [0:15];
    int          wcyc_a [0:15];
    int          wn_a, pulses_a, multi_a, width_a, stab_a, done_a, bnd_cd, bnd_idx;
    logic [7:0]  bnd_rom  [0:1];
    logic [1:0]  bnd_addr [0:1];
    logic        prev_low, after_pulse;
    logic [1:0]  prev_addr;
    logic [31:0] prev_data;

    always @(negedge clk) begin : mon_a
        int cyc, lows;
        logic [1:0] kind;
        if (!rst_a) begin
            wn_a = 0; pulses_a = 0; multi_a = 0; width_a = 0; stab_a = 0; done_a = 0;
            bnd_cd = 0; bnd_idx = 0; prev_low = 1'b0; after_pulse = 1'b0;
        end else begin
            cyc  = edges_a + 1;
            lows = int'(!cwe_a) + int'(!swe_a) + int'(!lwe_a);
            kind = !cwe_a ? 2'd0 : (!swe_a ? 2'd1 : 2'd2);
            if (bnd_cd > 0) begin
                bnd_cd--;
                if (bnd_cd == 0) begin
                    bnd_rom[bnd_idx]  = rom_addr_a;
                    bnd_addr[bnd_idx] = addr_a;
                end
            end
            if (lows > 1) multi_a++;
            if (lows != 0) begin
                if (prev_low) width_a++;
                if (addr_a !== prev_addr || data_a !== prev_data) stab_a++;
                if (wn_a < 16) begin
                    wlog_a[wn_a] = {8'(kind), 24'(addr_a), data_a};
                    wcyc_a[wn_a] = cyc;
                end
                wn_a++;
                pulses_a++;
                after_pulse = 1'b1;
                if (addr_a == 2'd3 && kind != 2'd2) begin
                    bnd_cd  = 2;
                    bnd_idx = int'(kind);
                end
            end else if (after_pulse) begin
                if (addr_a !== prev_addr || data_a !== prev_data) stab_a++;
                after_pulse = 1'b0;
            end
            if (!nb_a && done_a == 0) done_a = edges_a;
            prev_low  = (lows != 0);
            prev_addr = addr_a;
            prev_data = data_a;
        end
    end

    // ---------------- instance B ----------------
    logic       rst_b = 1'b0;
    logic [7:0] rom_addr_b;
    logic       rom_n_oe_b;
    logic [0:0] addr_b;
    logic [31:0] data_b;
    logic       cwe_b, swe_b, lwe_b, nb_b;

    boot_sequencer #(.UCODE_AW(1), .SLICE_AW(1), .LOOK_AW(1), .ROM_AW(8), .ROM_LAT(3)) u_b (
        .CLK(clk), .N_RST(rst_b), .ROM_ADDR(rom_addr_b), .ROM_N_OE(rom_n_oe_b),
        .ROM_DATA(rom_addr_b), .ADDR(addr_b), .DATA(data_b), .CONTROL_N_WE(cwe_b),
        .MLU_SLICE_N_WE(swe_b), .MLU_LOOKAHEAD_N_WE(lwe_b), .N_BOOTED(nb_b));

    int edges_b;
    always @(posedge clk or negedge rst_b)
        if (!rst_b) edges_b <= 0;
        else        edges_b <= edges_b + 1;

    logic [7:0]  rs_b [0:11];
    int          first_b, done_b, wn_b;
    logic [63:0] first_w_b, last_w_b;

    always @(negedge clk) begin : mon_b
        int cyc;
        if (!rst_b) begin
            first_b = 0; done_b = 0; wn_b = 0; first_w_b = '0; last_w_b = '0;
        end else begin
            cyc = edges_b + 1;
            if (cyc <= 12) rs_b[cyc-1] = rom_addr_b;
            if (!cwe_b || !swe_b || !lwe_b) begin
                last_w_b = {8'(!cwe_b ? 0 : (!swe_b ? 1 : 2)), 24'(addr_b), data_b};
                if (wn_b == 0) begin
                    first_b   = cyc;
                    first_w_b = last_w_b;
                end
                wn_b++;
            end
            if (!nb_b && done_b == 0) done_b = edges_b;
        end
    end

    // ---------------- helpers ----------------
    task automatic run_a_to_done();
        @(negedge clk);
        rst_a = 1'b1;
        for (int i = 0; i < 400 && done_a == 0; i++) @(negedge clk);
        check("a_boot_time", 64'(done_a), 64'(T_A));
    endtask

    task automatic check_writes_a(input string pass);
        logic [63:0] exp;
        int          ecyc;
        check({pass, "_write_count"}, 64'(wn_a), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin
                exp  = {8'd0, 24'(i), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
                ecyc = 7*i + 6;
            end else if (i < 8) begin
                exp  = {8'd1, 24'(i-4), 32'(16 + i - 4)};
                ecyc = 28 + 4*(i-4) + 3;
            end else begin
                exp  = {8'd2, 24'(i-8), 32'(20 + i - 8)};
                ecyc = 44 + 4*(i-8) + 3;
            end
            check($sformatf("%s_write%0d", pass, i), wlog_a[i], exp);
            check($sformatf("%s_wcyc%0d", pass, i), 64'(wcyc_a[i]), 64'(ecyc));
        end
    endtask

    initial begin
        // reset state
        #12;
        check("rst_rom_addr", 64'(rom_addr_a), 64'd0);
        check("rst_addr_data", {30'(addr_a), data_a}, 64'd0);
        check("rst_strobes", {cwe_a, swe_a, lwe_a, nb_a, rom_n_oe_a}, {5'b11110});
        repeat (2) @(negedge clk);

        // full load, write sequence and strobe rules
        run_a_to_done();
        check_writes_a("run1");
        check("pulse_count", 64'(pulses_a), 64'd12);
        check("multi_low", 64'(multi_a), 64'd0);
        check("pulse_width", 64'(width_a), 64'd0);
        check("addr_data_stable", 64'(stab_a), 64'd0);
        check("bnd_slice_start", {bnd_addr[0], bnd_rom[0]}, {2'd0, 8'd16});
        check("bnd_look_start", {bnd_addr[1], bnd_rom[1]}, {2'd0, 8'd20});

        // DONE is terminal regardless of ROM_DATA
        rom_rand = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rnd = 8'($urandom);
        end
        rom_rand = 1'b0;
        check("done_no_writes", 64'(pulses_a), 64'd12);
        check("done_flags", {nb_a, rom_n_oe_a, cwe_a, swe_a, lwe_a}, 5'b01111);
        check("done_frozen", {22'(rom_addr_a), addr_a, data_a}, {22'd24, 2'd3, 32'h17});

        // reset in the 2nd slice WRITE cycle, then full reload
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        begin : wait_slice
            int ns;
            ns = 0;
            for (int i = 0; i < 200 && ns < 2; i++) begin
                @(posedge clk);
                #1;
                if (!swe_a) ns++;
            end
            check("mid_slice_reached", 64'(ns), 64'd2);
        end
        rst_a = 1'b0;
        #1;
        check("mid_rst_slice_we", 64'(swe_a), 64'd1);
        check("mid_rst_addr", 64'(addr_a), 64'd0);
        check("mid_rst_flags", {nb_a, rom_n_oe_a, 22'(rom_addr_a), data_a}, {1'b1, 1'b0, 22'd0, 32'd0});
        repeat (2) @(negedge clk);
        run_a_to_done();
        check_writes_a("run2");

        // ROM_LAT=3 timing instance
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 400 && done_b == 0; i++) @(negedge clk);
        check("b_boot_time", 64'(done_b), 64'(T_B));
        check("b_first_write_cyc", 64'(first_b), 64'd14);
        check("b_first_write", first_w_b, {8'd0, 24'd0, 32'h03020100});
        check("b_last_write", last_w_b, {8'd2, 24'd1, 32'h0B});
        check("b_write_count", 64'(wn_b), 64'd6);
        for (int k = 0; k < 12; k++)
            check($sformatf("b_rom_addr_cyc%0d", k+1), 64'(rs_b[k]), 64'(k/3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
